// File: rtl/fifo_arbiter_pkg.sv
// Shared types and constants for the fifo_arbiter slice: FSM encoding,
// requester indices and the default write-ack timeout.
package fifo_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD_ISSUE,
    S_RD_DATA
  } state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  localparam int REQ_R = 2;

  localparam int ACK_TIMEOUT_DEF = 2;

  // One-hot winner to requester index; an all-zero input maps to A.
  function automatic logic [1:0] win_idx(input logic [2:0] oh);
    if (oh[REQ_R])      return 2'(REQ_R);
    else if (oh[REQ_B]) return 2'(REQ_B);
    else                return 2'(REQ_A);
  endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// Requester + FIFO-side signal bundle for fifo_arbiter. The slave modport is
// the arbiter; master is the requesters/FIFO environment.
interface fifo_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 5
);
  logic              fifo_arbiter_port_req_a;
  logic [DATA_W-1:0] fifo_arbiter_port_din_a;
  logic              fifo_arbiter_port_gnt_a;
  logic              fifo_arbiter_port_req_b;
  logic [DATA_W-1:0] fifo_arbiter_port_din_b;
  logic              fifo_arbiter_port_gnt_b;
  logic              fifo_arbiter_port_req_r;
  logic              fifo_arbiter_port_gnt_r;
  logic              fifo_arbiter_port_wr_en;
  logic [DATA_W-1:0] fifo_arbiter_port_wdata;
  logic              fifo_arbiter_port_rd_en;
  logic              fifo_arbiter_port_full;
  logic              fifo_arbiter_port_empty;
  logic              fifo_arbiter_port_ack;
  logic [CNT_W-1:0]  fifo_arbiter_port_count;
  logic              fifo_arbiter_port_wr_err;

  modport slave (
    input  fifo_arbiter_port_req_a, fifo_arbiter_port_din_a,
    input  fifo_arbiter_port_req_b, fifo_arbiter_port_din_b,
    input  fifo_arbiter_port_req_r,
    input  fifo_arbiter_port_full, fifo_arbiter_port_empty, fifo_arbiter_port_ack,
    output fifo_arbiter_port_gnt_a, fifo_arbiter_port_gnt_b, fifo_arbiter_port_gnt_r,
    output fifo_arbiter_port_wr_en, fifo_arbiter_port_wdata, fifo_arbiter_port_rd_en,
    output fifo_arbiter_port_count, fifo_arbiter_port_wr_err
  );

  modport master (
    output fifo_arbiter_port_req_a, fifo_arbiter_port_din_a,
    output fifo_arbiter_port_req_b, fifo_arbiter_port_din_b,
    output fifo_arbiter_port_req_r,
    output fifo_arbiter_port_full, fifo_arbiter_port_empty, fifo_arbiter_port_ack,
    input  fifo_arbiter_port_gnt_a, fifo_arbiter_port_gnt_b, fifo_arbiter_port_gnt_r,
    input  fifo_arbiter_port_wr_en, fifo_arbiter_port_wdata, fifo_arbiter_port_rd_en,
    input  fifo_arbiter_port_count, fifo_arbiter_port_wr_err
  );

endinterface

// File: rtl/fifo_arbiter_rr_pick3.sv
// Combinational 3-way picker: eligible vector + last winner -> one-hot winner.
// FIFO_ARBITER_FIXED_PRIO_EN selects fixed priority R > A > B instead.
module rr_pick3
  import fifo_arbiter_pkg::*;
(
  input  logic [2:0] i_elig,
  input  logic [1:0] i_last,
  output logic [2:0] o_win
);

`ifdef FIFO_ARBITER_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;

  always_comb begin
    o_win = '0;
    if (i_elig[REQ_R])      o_win[REQ_R] = 1'b1;
    else if (i_elig[REQ_A]) o_win[REQ_A] = 1'b1;
    else if (i_elig[REQ_B]) o_win[REQ_B] = 1'b1;
  end
`else
  logic [2:0] w_rot;
  logic [2:0] w_pick;

  // Rotate so bit 0 is the requester right after the last winner, take the
  // lowest set bit, then rotate back.
  always_comb begin
    case (i_last)
      2'(REQ_A): w_rot = {i_elig[REQ_A], i_elig[REQ_R], i_elig[REQ_B]};
      2'(REQ_B): w_rot = {i_elig[REQ_B], i_elig[REQ_A], i_elig[REQ_R]};
      default:   w_rot = i_elig;
    endcase
  end

  assign w_pick = w_rot & (~w_rot + 3'd1);

  always_comb begin
    case (i_last)
      2'(REQ_A): o_win = {w_pick[1], w_pick[0], w_pick[2]};
      2'(REQ_B): o_win = {w_pick[0], w_pick[2], w_pick[1]};
      default:   o_win = w_pick;
    endcase
  end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// Sequences two writers and one reader onto a single FIFO port set, one
// transaction at a time. FIFO_ARBITER_FIXED_PRIO_EN: fixed R > A > B priority.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 5,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic            fifo_arbiter_port_clk,
  input  logic            fifo_arbiter_port_rst,
  fifo_arbiter_if.slave   bus
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t            r_state, w_nxt;
  logic [1:0]        r_last, r_cur;
  logic [TMO_W-1:0]  r_tmo;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr_en, r_rd_en, r_gnt_a, r_gnt_b, r_gnt_r, r_wr_err;
  logic [2:0]        w_elig, w_win;
  logic              w_ack_ok, w_tmo_hit;

  // FIFO flags are authoritative; the shadow count only saturates on mismatch.
  assign w_elig = {bus.fifo_arbiter_port_req_r & ~bus.fifo_arbiter_port_empty,
                   bus.fifo_arbiter_port_req_b & ~bus.fifo_arbiter_port_full,
                   bus.fifo_arbiter_port_req_a & ~bus.fifo_arbiter_port_full};

  rr_pick3 u_pick (
    .i_elig (w_elig),
    .i_last (r_last),
    .o_win  (w_win)
  );

  always_comb begin
    w_nxt     = r_state;
    w_ack_ok  = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win[REQ_R])  w_nxt = S_RD_ISSUE;
        else if (|w_win)   w_nxt = S_WR_ISSUE;
      end
      S_WR_ISSUE: w_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.fifo_arbiter_port_ack) begin
          w_ack_ok = 1'b1;
          w_nxt    = S_IDLE;
        end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
          w_tmo_hit = 1'b1;
          w_nxt     = S_IDLE;
        end
      end
      S_RD_ISSUE: w_nxt = S_RD_DATA;
      S_RD_DATA:  w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge fifo_arbiter_port_clk) begin
    if (fifo_arbiter_port_rst) begin
      r_state  <= S_IDLE;
      r_last   <= 2'(REQ_R);
      r_cur    <= 2'(REQ_A);
      r_tmo    <= '0;
      r_count  <= '0;
      r_wdata  <= '0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_gnt_r  <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_wr_en  <= (w_nxt == S_WR_ISSUE);
      r_rd_en  <= (w_nxt == S_RD_ISSUE);
      r_gnt_a  <= w_ack_ok && (r_cur == 2'(REQ_A));
      r_gnt_b  <= w_ack_ok && (r_cur == 2'(REQ_B));
      r_gnt_r  <= (r_state == S_RD_ISSUE);
      r_wr_err <= w_tmo_hit;

      if (r_state == S_WR_ISSUE)     r_tmo <= '0;
      else if (r_state == S_WR_WAIT) r_tmo <= r_tmo + TMO_W'(1);

      if (r_state == S_IDLE && |w_win) begin
        r_cur <= win_idx(w_win);
        if (!w_win[REQ_R])
          r_wdata <= w_win[REQ_A] ? bus.fifo_arbiter_port_din_a : bus.fifo_arbiter_port_din_b;
      end

      // Pointer and count move only on a committed grant, never on abort.
      if (w_ack_ok) begin
        r_last <= r_cur;
        if (r_count != CNT_W'(DEPTH)) r_count <= r_count + CNT_W'(1);
      end else if (r_state == S_RD_ISSUE) begin
        r_last <= 2'(REQ_R);
        if (r_count != '0) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign bus.fifo_arbiter_port_gnt_a  = r_gnt_a;
  assign bus.fifo_arbiter_port_gnt_b  = r_gnt_b;
  assign bus.fifo_arbiter_port_gnt_r  = r_gnt_r;
  assign bus.fifo_arbiter_port_wr_en  = r_wr_en;
  assign bus.fifo_arbiter_port_wdata  = r_wdata;
  assign bus.fifo_arbiter_port_rd_en  = r_rd_en;
  assign bus.fifo_arbiter_port_count  = r_count;
  assign bus.fifo_arbiter_port_wr_err = r_wr_err;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with a small 16-entry FIFO model supplying
// full/empty/wr_ack/dout; expected grants and counts are hand-derived.
module tb_fifo_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_arbiter_if #(.DATA_W(4), .CNT_W(5)) bus ();

  fifo_arbiter #(.DATA_W(4), .DEPTH(16), .CNT_W(5), .ACK_TIMEOUT(2)) dut (
    .fifo_arbiter_port_clk (clk),
    .fifo_arbiter_port_rst (rst),
    .bus                   (bus)
  );

  logic       req_a, req_b, req_r, force_full, kill_ack;
  logic [3:0] din_a, din_b;
  assign bus.fifo_arbiter_port_req_a = req_a;
  assign bus.fifo_arbiter_port_din_a = din_a;
  assign bus.fifo_arbiter_port_req_b = req_b;
  assign bus.fifo_arbiter_port_din_b = din_b;
  assign bus.fifo_arbiter_port_req_r = req_r;

  wire       gnt_a  = bus.fifo_arbiter_port_gnt_a;
  wire       gnt_b  = bus.fifo_arbiter_port_gnt_b;
  wire       gnt_r  = bus.fifo_arbiter_port_gnt_r;
  wire       wr_en  = bus.fifo_arbiter_port_wr_en;
  wire       rd_en  = bus.fifo_arbiter_port_rd_en;
  wire       wr_err = bus.fifo_arbiter_port_wr_err;
  wire [3:0] wdata  = bus.fifo_arbiter_port_wdata;
  wire [4:0] count  = bus.fifo_arbiter_port_count;

  // FIFO model
  logic [3:0] mem [16];
  int         wp, rp, qn;
  logic [3:0] m_dout;
  logic       m_full, m_empty, m_wr_ok, m_rd_ok;
  assign m_full  = (qn == 16) || force_full;
  assign m_empty = (qn == 0);
  assign m_wr_ok = wr_en && !m_full && !kill_ack;
  assign m_rd_ok = rd_en && !m_empty;
  assign bus.fifo_arbiter_port_full  = m_full;
  assign bus.fifo_arbiter_port_empty = m_empty;

  always @(posedge clk) begin
    if (rst) begin
      wp <= 0; rp <= 0; qn <= 0; m_dout <= '0;
      bus.fifo_arbiter_port_ack <= 1'b0;
    end else begin
      bus.fifo_arbiter_port_ack <= m_wr_ok;
      if (m_wr_ok) begin mem[wp] <= wdata; wp <= (wp + 1) % 16; end
      if (m_rd_ok) begin m_dout <= mem[rp]; rp <= (rp + 1) % 16; end
      qn <= qn + (m_wr_ok ? 1 : 0) - (m_rd_ok ? 1 : 0);
    end
  end

  int viol = 0, wr_pulses = 0;
  always @(negedge clk) begin
    if (wr_en && rd_en) viol <= viol + 1;
    if (wr_en) wr_pulses <= wr_pulses + 1;
  end

  int checks = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 0; req_b = 0; req_r = 0; force_full = 0; kill_ack = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for any grant, then check which one, the count and dout.
  task automatic expect_grant(input string tag, input logic [2:0] exp_g, input int exp_cnt,
                              input bit chk_dout, input logic [3:0] exp_dout);
    int n = 0;
    while (!(gnt_a | gnt_b | gnt_r) && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_gnt"}, {29'd0, gnt_r, gnt_b, gnt_a}, {29'd0, exp_g});
    chk({tag, "_cnt"}, {27'd0, count}, exp_cnt);
    if (chk_dout) chk({tag, "_dout"}, {28'd0, m_dout}, {28'd0, exp_dout});
  endtask

  task automatic wait_wr_en(input string tag);
    int n = 0;
    while (!wr_en && n < 20) begin @(negedge clk); n++; end
    chk(tag, {31'd0, wr_en}, 1);
  endtask

  initial begin
    din_a = 0; din_b = 0;
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pulses", {28'd0, wr_err, gnt_r, gnt_b, gnt_a}, 0);
    chk("rst_en", {30'd0, wr_en, rd_en}, 0);
    chk("rst_wdata", {28'd0, wdata}, 0);
    chk("rst_cnt", {27'd0, count}, 0);
    rst = 1'b0;

    // single write from A: 3-cycle latency to gnt
    req_a = 1; din_a = 4'h5;
    @(negedge clk);
    chk("t1_wr_en", {31'd0, wr_en}, 1);
    chk("t1_wdata", {28'd0, wdata}, 5);
    @(negedge clk);
    chk("t1_wr_en_off", {31'd0, wr_en}, 0);
    chk("t1_ack", {31'd0, bus.fifo_arbiter_port_ack}, 1);
    @(negedge clk);
    chk("t1_gnt_a", {31'd0, gnt_a}, 1);
    chk("t1_cnt", {27'd0, count}, 1);
    req_a = 0;
    @(negedge clk);
    chk("t1_gnt_once", {31'd0, gnt_a}, 0);

`ifndef FIFO_ARBITER_FIXED_PRIO_EN
    // A and B held: alternate
    do_reset();
    din_a = 1; din_b = 2; req_a = 1; req_b = 1;
    expect_grant("t2_a1", 3'b001, 1, 0, 0); @(negedge clk);
    expect_grant("t2_b1", 3'b010, 2, 0, 0); @(negedge clk);
    expect_grant("t2_a2", 3'b001, 3, 0, 0); @(negedge clk);
    expect_grant("t2_b2", 3'b010, 4, 0, 0);
    req_a = 0; req_b = 0;
    @(negedge clk);

    // prefill 1..4, read one (count 3, pointer after R), then A+R interleave
    do_reset();
    din_a = 1; req_a = 1;
    for (int i = 0; i < 4; i++) begin
      expect_grant("t3_fill", 3'b001, i + 1, 0, 0);
      if (i == 3) req_a = 0; else din_a = 4'(i + 2);
      @(negedge clk);
    end
    req_r = 1;
    expect_grant("t3_pre", 3'b100, 3, 1, 4'h1);
    req_a = 1; din_a = 4'h7;
    @(negedge clk);
    expect_grant("t3_a1", 3'b001, 4, 0, 0); @(negedge clk);
    expect_grant("t3_r1", 3'b100, 3, 1, 4'h2); @(negedge clk);
    expect_grant("t3_a2", 3'b001, 4, 0, 0); @(negedge clk);
    expect_grant("t3_r2", 3'b100, 3, 1, 4'h3);
    req_a = 0; req_r = 0;
    @(negedge clk);

    // full blocks A, R still served; A granted once full drops
    begin
      int p0;
      force_full = 1; req_a = 1; req_r = 1; p0 = wr_pulses;
      expect_grant("t4_r", 3'b100, 2, 1, 4'h4);
      req_r = 0;
      repeat (6) @(negedge clk);
      chk("t4_no_wr", wr_pulses - p0, 0);
      force_full = 0;
      expect_grant("t4_a", 3'b001, 3, 0, 0);
    end

    // ack withheld: wr_err after timeout, count unchanged, A retried
    kill_ack = 1; din_a = 4'h9;
    @(negedge clk);
    wait_wr_en("t5_wr_en");
    @(negedge clk);
    @(negedge clk);
    chk("t5_err_early", {31'd0, wr_err}, 0);
    @(negedge clk);
    chk("t5_err", {31'd0, wr_err}, 1);
    chk("t5_no_gnt", {31'd0, gnt_a}, 0);
    chk("t5_cnt", {27'd0, count}, 3);
    kill_ack = 0;
    expect_grant("t5_retry", 3'b001, 4, 0, 0);
    req_a = 0;
    @(negedge clk);
`endif

    // reset landing in WR_WAIT
    req_a = 1; din_a = 4'h3;
    wait_wr_en("t6_wr_en");
    @(negedge clk);
    rst = 1'b1; req_a = 0;
    @(negedge clk);
    chk("t6_out", {26'd0, gnt_a, gnt_b, gnt_r, wr_err, wr_en, rd_en}, 0);
    chk("t6_wdata", {28'd0, wdata}, 0);
    chk("t6_cnt", {27'd0, count}, 0);
    rst = 1'b0;

    // one entry, then A, B and R all at once
    din_a = 4'h1; din_b = 4'h2; req_a = 1;
    expect_grant("t7_fill", 3'b001, 1, 0, 0);
    req_b = 1; req_r = 1;
    @(negedge clk);
`ifdef FIFO_ARBITER_FIXED_PRIO_EN
    expect_grant("t7_first", 3'b100, 0, 1, 4'h1);
`else
    expect_grant("t7_first", 3'b010, 2, 0, 0);
`endif
    req_a = 0; req_b = 0; req_r = 0;
    @(negedge clk);

    chk("excl_wr_rd", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
